// File: rtl/board_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : board_ram_arbiter
// Purpose  : Shares the snake board RAM between the renderer (active video) and
//            the updater (vertical blanking), and generates the game-speed tick.
//            Optional: BOARD_ARB_RD_PRIORITY_EN lets renderer reads preempt the
//            updater during the update window.
// Revision : 1.0 - initial release
// ============================================================================
module board_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_animate,
    input  logic              i_screenend,
    input  logic [3:0]        i_frames_per_tick,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_up_req,
    input  logic              i_up_we,
    input  logic [ADDR_W-1:0] i_up_addr,
    input  logic [DATA_W-1:0] i_up_wdata,
    output logic              o_up_gnt,
    output logic [DATA_W-1:0] o_up_rdata,
    output logic              o_up_rvalid,
    output logic              o_tick,
    output logic              o_rd_miss,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    typedef enum logic [0:0] {
        ST_RENDER = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    state_t            state_q;
    logic              anim_q;
    logic              end_q;
    logic [3:0]        frame_cnt_q;
    logic              tick_q;
    logic              rd_valid_q;
    logic              up_rvalid_q;
    logic              rd_miss_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              anim_rise;
    logic              end_rise;
    logic              in_update;
    logic              up_gnt;
    logic              rd_acc;
    logic              up_acc;
    logic              rd_refused;
    logic [4:0]        frame_next;
    logic [4:0]        frame_lim;
    logic              tick_hit;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    assign anim_rise = i_animate & ~anim_q;
    assign end_rise  = i_screenend & ~end_q;
    assign in_update = (state_q == ST_UPDATE);

`ifdef BOARD_ARB_RD_PRIORITY_EN
    assign up_gnt     = in_update & ~i_rd_req;
    assign rd_acc     = i_rd_req;
    assign rd_refused = 1'b0;
`else
    assign up_gnt     = in_update;
    assign rd_acc     = i_rd_req & ~in_update;
    assign rd_refused = i_rd_req & in_update;
`endif

    assign up_acc = i_up_req & up_gnt;

    // Frame counter compare is done one bit wider so count+1 never wraps.
    assign frame_next = {1'b0, frame_cnt_q} + 5'd1;
    assign frame_lim  = (i_frames_per_tick == 4'd0) ? 5'd1 : {1'b0, i_frames_per_tick};
    assign tick_hit   = (frame_next >= frame_lim);

    // An idle port keeps presenting the last address and write data.
    assign addr_d  = rd_acc ? i_rd_addr : (up_acc ? i_up_addr : addr_q);
    assign wdata_d = up_acc ? i_up_wdata : wdata_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_RENDER;
            anim_q      <= 1'b0;
            end_q       <= 1'b0;
            frame_cnt_q <= 4'd0;
            tick_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            up_rvalid_q <= 1'b0;
            rd_miss_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            anim_q      <= i_animate;
            end_q       <= i_screenend;
            tick_q      <= 1'b0;
            rd_valid_q  <= rd_acc;
            up_rvalid_q <= up_acc & ~i_up_we;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if (rd_refused) begin
                rd_miss_q <= 1'b1;
            end
            case (state_q)
                ST_RENDER: begin
                    if (anim_rise) begin
                        state_q <= ST_UPDATE;
                        // Tick lands on the first cycle of the new update window.
                        if (tick_hit) begin
                            frame_cnt_q <= 4'd0;
                            tick_q      <= 1'b1;
                        end else begin
                            frame_cnt_q <= frame_next[3:0];
                        end
                    end
                end
                ST_UPDATE: begin
                    if (end_rise) begin
                        state_q <= ST_RENDER;
                    end
                end
                default: state_q <= ST_RENDER;
            endcase
        end
    end

    assign o_up_gnt    = up_gnt;
    assign o_ram_addr  = addr_d;
    assign o_ram_wdata = wdata_d;
    assign o_ram_we    = up_acc & i_up_we;
    assign o_rd_valid  = rd_valid_q;
    assign o_up_rvalid = up_rvalid_q;
    assign o_rd_data   = rd_valid_q ? i_ram_rdata : '0;
    assign o_up_rdata  = up_rvalid_q ? i_ram_rdata : '0;
    assign o_tick      = tick_q;
    assign o_rd_miss   = rd_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_board_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_ram_arbiter
// Purpose  : Randomized scoreboard bench for board_ram_arbiter with a board RAM
//            model and a frame-level reference of windows, ticks and misses.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_board_ram_arbiter;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 2;
`ifdef BOARD_ARB_RD_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, animate, screenend, rd_req, up_req, up_we;
    logic [3:0]        fpt;
    logic [ADDR_W-1:0] rd_addr, up_addr, ram_addr;
    logic [DATA_W-1:0] up_wdata, rd_data, up_rdata, ram_wdata, ram_rdata;
    logic              rd_valid, up_gnt, up_rvalid, tick, rd_miss, ram_we;

    board_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_animate(animate), .i_screenend(screenend),
        .i_frames_per_tick(fpt), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_up_req(up_req), .i_up_we(up_we),
        .i_up_addr(up_addr), .i_up_wdata(up_wdata), .o_up_gnt(up_gnt),
        .o_up_rdata(up_rdata), .o_up_rvalid(up_rvalid), .o_tick(tick),
        .o_rd_miss(rd_miss), .o_ram_addr(ram_addr), .o_ram_we(ram_we),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    // Synchronous-read single-port board RAM
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Reference model state
    logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] up_q[$];
    int  frame_cnt_m = 0;
    int  tick_exp_total = 0;
    int  tick_seen = 0;
    bit  st_m = 1'b0;
    bit  miss_m = 1'b0;
    int  pass_cnt = 0;
    int  total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (tick) tick_seen++;
            if (rd_valid) begin
                if (rd_q.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
                else check("rd_data", rd_data, rd_q.pop_front());
            end else begin
                check("rd_data_idle", rd_data, 0);
            end
            if (up_rvalid) begin
                if (up_q.size() == 0) check("up_rvalid_unexpected", up_rvalid, 0);
                else check("up_rdata", up_rdata, up_q.pop_front());
            end else begin
                check("up_rdata_idle", up_rdata, 0);
            end
        end
    end

    task automatic idle_inputs();
        rd_req = 0; up_req = 0; up_we = 0;
    endtask

    task automatic bus_cycle(input bit ur, input bit uwe, input logic [ADDR_W-1:0] ua,
                             input logic [DATA_W-1:0] ud, input bit rr,
                             input logic [ADDR_W-1:0] ra, input bit se);
        bit upd, up_ok, rd_ok;
        @(posedge clk); #1;
        upd = st_m;
        up_req = ur; up_we = uwe; up_addr = ua; up_wdata = ud;
        rd_req = rr; rd_addr = ra; screenend = se;
        rd_ok = rr & (PRIO | ~upd);
        up_ok = ur & upd & ~(PRIO & rr);
        if (rr & upd & ~PRIO) miss_m = 1'b1;
        if (rd_ok) rd_q.push_back(model_mem[ra]);
        if (up_ok) begin
            if (uwe) model_mem[ua] = ud;
            else up_q.push_back(model_mem[ua]);
        end
        @(negedge clk);
        check("up_gnt", up_gnt, upd & ~(PRIO & rr));
        check("ram_we", ram_we, up_ok & uwe);
        if (rd_ok || up_ok) check("ram_addr", ram_addr, rd_ok ? ra : ua);
        if (up_ok && uwe) check("ram_wdata", ram_wdata, ud);
    endtask

    task automatic rand_update();
        bit rr = ($urandom % 8 == 0);
        bit ur = ($urandom % 4 != 0);
        logic [ADDR_W-1:0] a = ($urandom % 4 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom % 32);
        bus_cycle(ur, 1'($urandom), a, DATA_W'($urandom), rr, ADDR_W'($urandom % 32), screenend);
    endtask

    task automatic rand_render(input bit se);
        bus_cycle(1'($urandom), 1'b1, ADDR_W'($urandom % 32), DATA_W'($urandom),
                  1'($urandom), ADDR_W'($urandom % 32), se);
    endtask

    task automatic open_frame();
        int  eff;
        bit  exp_tick;
        @(posedge clk); #1;
        idle_inputs();
        animate = 1'b1;
        @(negedge clk);
        check("gnt_before_edge", up_gnt, 0);
        eff = (fpt == 0) ? 1 : int'(fpt);
        frame_cnt_m++;
        exp_tick = (frame_cnt_m >= eff);
        if (exp_tick) begin
            frame_cnt_m = 0;
            tick_exp_total++;
        end
        st_m = 1'b1;
        @(negedge clk);
        check("gnt_open", up_gnt, 1);
        check("tick_first", tick, exp_tick);
        @(negedge clk);
        check("tick_second", tick, 0);
        repeat (2) @(posedge clk);
        #1 animate = 1'b0;
    endtask

    task automatic close_frame(input int nrd);
        bus_cycle(1'($urandom), 1'($urandom), ADDR_W'($urandom % 32), DATA_W'($urandom),
                  1'b0, '0, 1'b1);
        st_m = 1'b0;
        for (int i = 0; i < nrd; i++) rand_render(i < 2);
        check("rd_miss", rd_miss, miss_m);
    endtask

    task automatic frame(input int f, input int nup, input int nrd);
        fpt = 4'(f);
        open_frame();
        for (int i = 0; i < nup; i++) rand_update();
        close_frame(nrd);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i] = DATA_W'($urandom);
            model_mem[i] = ram[i];
        end
        rst_n = 0; animate = 0; screenend = 0; fpt = 4'd1;
        idle_inputs(); rd_addr = '0; up_addr = '0; up_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_up_gnt", up_gnt, 0);
        check("rst_tick", tick, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_up_rvalid", up_rvalid, 0);
        check("rst_rd_miss", rd_miss, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        @(posedge clk); #1 rst_n = 1;

        // Render phase: updater pending writes have no effect, read of 0x000
        bus_cycle(1, 1, 11'h12C, 2'b01, 1, 11'h000, 0);
        bus_cycle(1, 1, 11'h12C, 2'b10, 0, '0, 0);
        for (int i = 0; i < 4; i++) rand_render(0);

        // First window: directed write/read of 0x12C, then a few random ops
        fpt = 4'd1;
        open_frame();
        bus_cycle(1, 1, 11'h12C, 2'b11, 0, '0, 0);
        bus_cycle(1, 0, 11'h12C, 2'b00, 0, '0, 0);
        bus_cycle(0, 0, '0, '0, 0, '0, 0);
        for (int i = 0; i < 6; i++) rand_update();
        close_frame(6);

        frame(1, 8, 6);
        for (int k = 0; k < 7; k++) frame(3, 6, 5);
        for (int k = 0; k < 3; k++) frame(0, 6, 5);
        for (int k = 0; k < 6; k++) frame(int'($urandom_range(0, 5)), 10, 8);

        // Reset during the tick cycle of a new window
        fpt = 4'd1;
        @(posedge clk); #1 idle_inputs(); animate = 1'b1;
        @(posedge clk); #2;
        check("pre_rst_gnt", up_gnt, 1);
        check("pre_rst_tick", tick, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", up_gnt, 0);
        check("async_rst_tick", tick, 0);
        check("async_rst_miss", rd_miss, 0);
        rd_q.delete(); up_q.delete();
        frame_cnt_m = 0; miss_m = 1'b0; st_m = 1'b0;
        @(posedge clk); #1 animate = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Screen-end before any animate keeps the renderer in control
        for (int i = 0; i < 5; i++) rand_render(i < 3);
        frame(2, 6, 4);
        frame(2, 6, 4);

        repeat (3) bus_cycle(0, 0, '0, '0, 0, '0, 0);
        check("rd_q_drain", rd_q.size(), 0);
        check("up_q_drain", up_q.size(), 0);
        check("tick_total", tick_seen, tick_exp_total);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
